reg_ul_access_mc: RTL
=====================

# reg_ul_access_mc

Parametrised multi-channel register bank for the user-logic CPU access path, sitting between the shell's register interface and user logic. Provides global version, scratch and vled registers plus NUM_CH independent add/accumulate channels, each with its own control FSM, sticky status and done interrupt. Adds a read-valid handshake, unmapped-address detection and an illegal-access counter.

## Interface
- CPU_ADDR_WIDTH, 12, CPU address width (≥ 12)
- CPU_DATA_WIDTH, 32, register data width
- NUM_CH, 4, channel count, 1..16
- VER_TIME, 32'h2018_0301, value of version-time register
- VER_TYPE, 32'h00D1_0007, value of version-type register

- clks  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_wr  in  1  write strobe, one cycle per access
- cpu_wr_addr  in  CPU_ADDR_WIDTH  shared read/write word address
- cpu_data_in  in  CPU_DATA_WIDTH  write data
- cpu_rd  in  1  read strobe, one cycle per access
- cpu_data_out  out  CPU_DATA_WIDTH  read data, valid with cpu_rd_vld
- cpu_rd_vld  out  1  one-cycle read-data-valid pulse
- ul2sh_vled  out  16  virtual LED register
- ch_done_irq  out  NUM_CH  one-cycle pulse per channel on completion

## Operation
- Global map: 0x000 VER_TIME (RO); 0x001 VER_TYPE (RO); 0x002 scratch (RW); 0x003 vled (RW, bits 15:0, upper bits read 0); 0x004 capability (RO, NUM_CH in [4:0]); 0x005 illegal-access counter (RO, any write clears to 0).
- Channel n base = 0x100 + 8*n: +0 opA (RW); +1 opB (RW); +2 ctrl (bit0 go, self-clearing, reads 0; bit1 mode, 0=add, 1=accumulate, RW; bit2 clr, self-clearing); +3 result (RO); +4 status (bit0 busy RO; bit1 done, bit2 overflow, bit3 go_drop — sticky, write-1-to-clear); +5 op count (RO, wraps).
- Channel offsets +6/+7, channels ≥ NUM_CH and all other addresses are unmapped.
- Channel FSM: IDLE -> CALC on go; CALC -> DONE unconditionally (result, overflow updated); DONE -> IDLE (done set, ch_done_irq pulse, op count +1).
- Add: result = opA + opB. Accumulate: result = result + opA. Computed CPU_DATA_WIDTH+1 wide; carry-out sets overflow; stored value per Configuration.
- clr in IDLE zeroes result next cycle; go and clr in same write: clr first, then operation starts (accumulate starts from 0).
- go or clr while busy: ignored, go_drop set. opA/opB/mode writes while busy are accepted; operands sampled on IDLE->CALC edge.
- Unmapped read: returns 32'hDEAD_BEEF with cpu_rd_vld. Unmapped read or write: illegal counter +1, saturates at all-ones. Writes to RO registers are ignored, not illegal.
- W1C write coinciding with a set event: set wins.

## Timing
- Reset: cpu_data_out 0, cpu_rd_vld 0, ul2sh_vled 0, ch_done_irq 0, all RW/status/counters 0, all FSMs IDLE.
- Read latency 2: cpu_rd at edge T -> cpu_rd_vld and data registered at edge T+1, held until next read.
- cpu_wr and cpu_rd same cycle, same address: write applied, read returns written value.
- go captured at edge T: busy=1 after T; result/overflow update at T+1; done=1, irq high, busy=0 after T+2. Back-to-back go accepted from cycle after busy drops.
- reset_n low mid-operation: FSM to IDLE immediately, no irq, no done.

## Configuration
- REG_UL_ACCESS_MC_SAT_EN defined: on carry-out, result clamps to all-ones; overflow set.
- Undefined: result wraps (low CPU_DATA_WIDTH bits); overflow set.

## Test plan
- Reset then read 0x000, 0x001, 0x004 -> 32'h2018_0301, 32'h00D1_0007, NUM_CH; each cpu_rd_vld exactly 2 cycles after cpu_rd.
- Ch0 opA=5, opB=7, go -> busy 2 cycles, result 12, done=1, ch_done_irq[0] one pulse; write status 0x2 -> done 0.
- Ch1 mode=1, opA=0xFFFF_FFF0, go twice -> overflow=1; result 0xFFFF_FFFF with SAT_EN, 0xFFFF_FFE0 without.
- go to ch2 while busy -> go_drop=1, op count increments once only.
- Read 0x0FF and write ch NUM_CH base -> 32'hDEAD_BEEF returned, counter at 0x005 = 2; write 0x005 -> 0.
- Assert reset_n during CALC -> no irq, status 0, result 0 after release.

Source files
------------

// File: rtl/reg_ul_access_mc.sv
// Register bank for the user-logic CPU path: global version/scratch/vled registers plus NUM_CH add/accumulate channels.
// Define REG_UL_ACCESS_MC_SAT_EN to clamp a channel result to all-ones on carry-out instead of wrapping.
module reg_ul_access_mc #(
    parameter int          CPU_ADDR_WIDTH = 12,
    parameter int          CPU_DATA_WIDTH = 32,
    parameter int          NUM_CH         = 4,
    parameter logic [31:0] VER_TIME       = 32'h2018_0301,
    parameter logic [31:0] VER_TYPE       = 32'h00D1_0007
) (
    input  logic                      clks,
    input  logic                      reset_n,
    input  logic                      cpu_wr,
    input  logic [CPU_ADDR_WIDTH-1:0] cpu_wr_addr,
    input  logic [CPU_DATA_WIDTH-1:0] cpu_data_in,
    input  logic                      cpu_rd,
    output logic [CPU_DATA_WIDTH-1:0] cpu_data_out,
    output logic                      cpu_rd_vld,
    output logic [15:0]               ul2sh_vled,
    output logic [NUM_CH-1:0]         ch_done_irq
);
    localparam int AW = CPU_ADDR_WIDTH;
    localparam int DW = CPU_DATA_WIDTH;
    localparam logic [DW-1:0] ZERO_W = {DW{1'b0}};
    localparam logic [DW-1:0] ONES_W = {DW{1'b1}};
    localparam logic [DW-1:0] ONE_W  = DW'(1'b1);
    localparam logic [DW-1:0] DEAD_W = DW'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_DONE = 2'd2} ch_state_t;

    function automatic logic glb_hit(input logic [AW-1:0] a);
        return (a[AW-1:3] == {(AW-3){1'b0}}) && (a[2:0] <= 3'd5);
    endfunction

    function automatic logic ch_hit(input logic [AW-1:0] a);
        return (a[AW-1:8] == (AW-8)'(1'b1)) && (a[7:3] < 5'(NUM_CH)) && (a[2:0] <= 3'd5);
    endfunction

    logic [DW-1:0]             scratch_r, ill_cnt_r, data_out_r, rd_data_s, rd_ch_s;
    logic [15:0]               vled_r;
    logic                      rd_pend_r, rd_vld_r, glb_wr_s, acc_ill_s;
    logic [AW-1:0]             rd_addr_r;
    logic [NUM_CH-1:0][DW-1:0] ch_rdata_s;
    logic [NUM_CH-1:0]         ch_irq_s;

    assign glb_wr_s  = cpu_wr && glb_hit(cpu_wr_addr);
    assign acc_ill_s = (cpu_wr || cpu_rd) && !glb_hit(cpu_wr_addr) && !ch_hit(cpu_wr_addr);

    // Global RW registers and the saturating illegal-access counter
    always_ff @(posedge clks or negedge reset_n) begin
        if (!reset_n) begin
            scratch_r <= ZERO_W;
            vled_r    <= 16'h0000;
            ill_cnt_r <= ZERO_W;
        end else begin
            if (glb_wr_s && (cpu_wr_addr[2:0] == 3'd2)) scratch_r <= cpu_data_in;
            if (glb_wr_s && (cpu_wr_addr[2:0] == 3'd3)) vled_r <= cpu_data_in[15:0];
            if (glb_wr_s && (cpu_wr_addr[2:0] == 3'd5)) ill_cnt_r <= ZERO_W;
            else if (acc_ill_s && (ill_cnt_r != ONES_W)) ill_cnt_r <= ill_cnt_r + ONE_W;
        end
    end

    // Read pipeline: capture the request, register the selected word on the following edge
    always_ff @(posedge clks or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_r  <= 1'b0;
            rd_addr_r  <= {AW{1'b0}};
            rd_vld_r   <= 1'b0;
            data_out_r <= ZERO_W;
        end else begin
            rd_pend_r <= cpu_rd;
            if (cpu_rd) rd_addr_r <= cpu_wr_addr;
            rd_vld_r <= rd_pend_r;
            if (rd_pend_r) data_out_r <= rd_data_s;
        end
    end

    // Read data select for the captured address
    always_comb begin
        rd_ch_s   = ZERO_W;
        rd_data_s = DEAD_W;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_ch_s = (rd_addr_r[7:3] == 5'(i)) ? ch_rdata_s[i] : rd_ch_s;
        end
        if (glb_hit(rd_addr_r)) begin
            case (rd_addr_r[2:0])
                3'd0:    rd_data_s = DW'(VER_TIME);
                3'd1:    rd_data_s = DW'(VER_TYPE);
                3'd2:    rd_data_s = scratch_r;
                3'd3:    rd_data_s = DW'(vled_r);
                3'd4:    rd_data_s = DW'(5'(NUM_CH));
                3'd5:    rd_data_s = ill_cnt_r;
                default: rd_data_s = DEAD_W;
            endcase
        end else if (ch_hit(rd_addr_r)) begin
            rd_data_s = rd_ch_s;
        end else begin
            rd_data_s = DEAD_W;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ch_state_t     state_r, state_nx_s;
        logic [DW-1:0] opa_r, opb_r, res_r, cnt_r, a_r, b_r, calc_res_s, rdata_s;
        logic [DW:0]   sum_s;
        logic          mode_r, done_r, ovf_r, drop_r, irq_r, busy_s, sel_s, go_s, clr_s, w1c_s;

        assign sel_s  = cpu_wr && ch_hit(cpu_wr_addr) && (cpu_wr_addr[7:3] == 5'(g));
        assign go_s   = sel_s && (cpu_wr_addr[2:0] == 3'd2) && cpu_data_in[0];
        assign clr_s  = sel_s && (cpu_wr_addr[2:0] == 3'd2) && cpu_data_in[2];
        assign w1c_s  = sel_s && (cpu_wr_addr[2:0] == 3'd4);
        assign busy_s = (state_r != ST_IDLE);
        assign sum_s  = {1'b0, a_r} + {1'b0, b_r};
`ifdef REG_UL_ACCESS_MC_SAT_EN
        assign calc_res_s = sum_s[DW] ? ONES_W : sum_s[DW-1:0];
`else
        assign calc_res_s = sum_s[DW-1:0];
`endif

        // Channel FSM next state
        always_comb begin
            state_nx_s = state_r;
            case (state_r)
                ST_IDLE: begin
                    if (go_s) state_nx_s = ST_CALC;
                    else      state_nx_s = ST_IDLE;
                end
                ST_CALC: state_nx_s = ST_DONE;
                ST_DONE: state_nx_s = ST_IDLE;
                default: state_nx_s = ST_IDLE;
            endcase
        end

        // Channel registers; set events take priority over write-1-to-clear
        always_ff @(posedge clks or negedge reset_n) begin
            if (!reset_n) begin
                state_r <= ST_IDLE;
                opa_r   <= ZERO_W;
                opb_r   <= ZERO_W;
                res_r   <= ZERO_W;
                cnt_r   <= ZERO_W;
                a_r     <= ZERO_W;
                b_r     <= ZERO_W;
                mode_r  <= 1'b0;
                done_r  <= 1'b0;
                ovf_r   <= 1'b0;
                drop_r  <= 1'b0;
                irq_r   <= 1'b0;
            end else begin
                state_r <= state_nx_s;
                irq_r   <= (state_r == ST_DONE);
                if (sel_s && (cpu_wr_addr[2:0] == 3'd0)) opa_r <= cpu_data_in;
                if (sel_s && (cpu_wr_addr[2:0] == 3'd1)) opb_r <= cpu_data_in;
                if (sel_s && (cpu_wr_addr[2:0] == 3'd2)) mode_r <= cpu_data_in[1];
                // A clear issued with go makes an accumulate start from zero
                if (!busy_s && go_s) begin
                    a_r <= opa_r;
                    b_r <= cpu_data_in[1] ? (clr_s ? ZERO_W : res_r) : opb_r;
                end
                if (state_r == ST_CALC) res_r <= calc_res_s;
                else if (!busy_s && clr_s) res_r <= ZERO_W;
                if (state_r == ST_DONE) cnt_r <= cnt_r + ONE_W;
                if (state_r == ST_DONE) done_r <= 1'b1;
                else if (w1c_s && cpu_data_in[1]) done_r <= 1'b0;
                if ((state_r == ST_CALC) && sum_s[DW]) ovf_r <= 1'b1;
                else if (w1c_s && cpu_data_in[2]) ovf_r <= 1'b0;
                if (busy_s && (go_s || clr_s)) drop_r <= 1'b1;
                else if (w1c_s && cpu_data_in[3]) drop_r <= 1'b0;
            end
        end

        // Channel read word for the captured offset
        always_comb begin
            rdata_s = ZERO_W;
            case (rd_addr_r[2:0])
                3'd0:    rdata_s = opa_r;
                3'd1:    rdata_s = opb_r;
                3'd2:    rdata_s = DW'({mode_r, 1'b0});
                3'd3:    rdata_s = res_r;
                3'd4:    rdata_s = DW'({drop_r, ovf_r, done_r, busy_s});
                3'd5:    rdata_s = cnt_r;
                default: rdata_s = ZERO_W;
            endcase
        end

        assign ch_rdata_s[g] = rdata_s;
        assign ch_irq_s[g]   = irq_r;
    end

    assign cpu_data_out = data_out_r;
    assign cpu_rd_vld   = rd_vld_r;
    assign ul2sh_vled   = vled_r;
    assign ch_done_irq  = ch_irq_s;
endmodule
